edp_muldiv_seq: RTL
===================

Name: edp_muldiv_seq

Overview:
- Microstep sequencer for the EBOX datapath (EDP) that runs iterative multiply (shift-add) and divide (non-restoring) operations.
- It drives the EDP AD function, AR/MQ selects and load/clear strobes for one step per eboxClk cycle, counting STEPS iterations.
- Steering decisions come from the live MQ LSB and AR sign fed back from EDP.
- It sits between CTL/CRAM decode and EDP; its outputs are ORed into the EDP control inputs while busy.

Parameters:
- STEPS, 36, iterations per operation (1..63).
- AD_A, 7'o37, AD function code for AD/A.
- AD_APB, 7'o06, AD function code for AD/A+B.
- AD_AMB, 7'o31, AD function code for AD/A-B.
- SEL_ADSHR, 3'd2, ARL/ARR select code for AD shifted right one bit.
- SEL_ADSHL, 3'd3, ARL/ARR select code for AD shifted left one bit.
- SEL_AD, 3'd4, ARL/ARR select code for AD unshifted.
- MQ_SHR, 2'd1, MQ select code for shift right with AD35 into MQ0.
- MQ_SHL, 2'd2, MQ select code for shift left with ~AD sign into MQ35.

Ports:
- eboxClk  in  1  EBOX clock; all state changes on posedge.
- eboxReset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- opDiv  in  1  0 = multiply, 1 = divide; latched with start.
- abort  in  1  synchronous cancel; overrides everything except reset.
- mq35  in  1  EDP_MQ[35], current cycle.
- arSign  in  1  EDP_AR[0], current cycle.
- busy  out  1  high in LOAD, STEP, FIX, DONE.
- done  out  1  one-cycle completion pulse.
- stepCount  out  [0:5]  current iteration index.
- CRAM_AD  out  [0:6]  AD function.
- CRAM_ADB  out  [0:2]  ADB select; 2 (BR) whenever AD uses B, else 0.
- CRAM_BRload  out  1  BR<-AR strobe.
- CTL_ARL_SEL  out  [0:2]  ARL source.
- CTL_ARR_SEL  out  [0:2]  ARR source.
- CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload  out  1 each  AR load strobes; always asserted together.
- CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr  out  1 each  AR clear strobes; always asserted together.
- CTL_MQ_SEL  out  [0:1]  MQ source.
- CTL_ADlong  out  1  AD/ADX joined as 72-bit.

Behaviour:
- Reset (eboxReset_n=0, async): state=IDLE, stepCount=0, latched op=0. All outputs 0 immediately and held until release.
- Outputs are combinational from the state register plus mq35 and arSign. EDP captures them on the next posedge.
- In IDLE every control output is 0.
- IDLE: start=1 latches opDiv; next state is LOAD. start=0 stays in IDLE. start is ignored in every other state (no queuing).
- LOAD (1 cycle):
  - CRAM_BRload=1.
  - MUL: AR clear strobes=1 (AR<-0).
  - DIV: no AR strobes.
  - stepCount<=0; next state is STEP.
- STEP, MUL:
  - CRAM_AD = mq35 ? AD_APB : AD_A.
  - AR selects = SEL_ADSHR with AR loads=1.
  - CTL_MQ_SEL = MQ_SHR; CTL_ADlong=1.
- STEP, DIV:
  - CRAM_AD = arSign ? AD_APB : AD_AMB.
  - AR selects = SEL_ADSHL with AR loads=1.
  - CTL_MQ_SEL = MQ_SHL; CTL_ADlong=1.
- STEP counting: stepCount increments each cycle. When stepCount==STEPS-1, next state is FIX for DIV, DONE for MUL. stepCount holds its final value through FIX and DONE.
- FIX (DIV only, 1 cycle):
  - arSign=1: CRAM_AD=AD_APB, AR selects=SEL_AD, AR loads=1 (restore remainder).
  - arSign=0: all controls 0.
  - Next state is DONE.
- DONE: done=1, busy=1, controls 0; next state is IDLE. stepCount returns to 0 on entering IDLE.
- Latency, counting the posedge that accepts start as edge 0: done is high in cycle STEPS+2 for MUL and STEPS+3 for DIV. A new start is accepted at the earliest in the cycle after DONE.
- abort=1 in any non-IDLE state: next state is IDLE, stepCount<=0, no done pulse. Controls are forced to 0 in the abort cycle itself.
- abort in IDLE: no effect; start is ignored that cycle.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Reset asserted mid-operation: outputs 0 immediately; the operation is lost and no done pulse follows.
- STEPS=1: a single STEP cycle. stepCount counter is 6 bits wide and never wraps for legal STEPS.

Test Plan:
- Reset: hold eboxReset_n=0 with start=1 -> all outputs 0, busy=0. After release, start accepted on the next posedge.
- MUL, STEPS=36, mq35 alternating 1,0 from the first STEP -> CRAM_AD alternates 7'o06/7'o37 for 36 cycles (18 of each), MQ_SEL=1 throughout, done high exactly at cycle 38, busy low at cycle 39.
- DIV, STEPS=36, arSign=1 on steps 0-9 else 0, arSign=1 during FIX -> 10 x 7'o06 then 26 x 7'o31, FIX issues 7'o06 with SEL_AD, done at cycle 39.
- DIV with arSign=0 during FIX -> FIX cycle all controls 0, done still at cycle 39.
- start pulsed at step 5 of a MUL -> ignored; a single done at cycle 38 and no second operation follows.
- abort at stepCount=12 -> controls 0 in that cycle, IDLE next cycle, no done, stepCount=0. Separately, eboxReset_n low at step 20 -> outputs 0 before the next clock edge.

Source files
------------

// File: rtl/edp_muldiv_seq_if.sv
// EDP multiply/divide sequencer bundle: requests and
// EDP feedback in, datapath control strobes out.
interface edp_muldiv_seq_if;
  logic       start;
  logic       opDiv;
  logic       abort;
  logic       mq35;
  logic       arSign;
  logic       busy;
  logic       done;
  logic [0:5] stepCount;
  logic [0:6] CRAM_AD;
  logic [0:2] CRAM_ADB;
  logic       CRAM_BRload;
  logic [0:2] CTL_ARL_SEL;
  logic [0:2] CTL_ARR_SEL;
  logic       CTL_AR00to08load;
  logic       CTL_AR09to17load;
  logic       CTL_ARRload;
  logic       CTL_AR00to11clr;
  logic       CTL_AR12to17clr;
  logic       CTL_ARRclr;
  logic [0:1] CTL_MQ_SEL;
  logic       CTL_ADlong;

  modport master (
    output start, opDiv, abort,
    output mq35, arSign,
    input  busy, done, stepCount,
    input  CRAM_AD, CRAM_ADB, CRAM_BRload,
    input  CTL_ARL_SEL, CTL_ARR_SEL,
    input  CTL_AR00to08load, CTL_AR09to17load,
    input  CTL_ARRload,
    input  CTL_AR00to11clr, CTL_AR12to17clr,
    input  CTL_ARRclr,
    input  CTL_MQ_SEL, CTL_ADlong
  );

  modport slave (
    input  start, opDiv, abort,
    input  mq35, arSign,
    output busy, done, stepCount,
    output CRAM_AD, CRAM_ADB, CRAM_BRload,
    output CTL_ARL_SEL, CTL_ARR_SEL,
    output CTL_AR00to08load, CTL_AR09to17load,
    output CTL_ARRload,
    output CTL_AR00to11clr, CTL_AR12to17clr,
    output CTL_ARRclr,
    output CTL_MQ_SEL, CTL_ADlong
  );
endinterface

// File: rtl/edp_muldiv_seq.sv
// Shift-add multiply / non-restoring divide microstep
// sequencer driving EDP controls one step per clock.
module edp_muldiv_seq #(
  parameter int unsigned STEPS     = 36,
  parameter logic [6:0]  AD_A      = 7'o37,
  parameter logic [6:0]  AD_APB    = 7'o06,
  parameter logic [6:0]  AD_AMB    = 7'o31,
  parameter logic [2:0]  SEL_ADSHR = 3'd2,
  parameter logic [2:0]  SEL_ADSHL = 3'd3,
  parameter logic [2:0]  SEL_AD    = 3'd4,
  parameter logic [1:0]  MQ_SHR    = 2'd1,
  parameter logic [1:0]  MQ_SHL    = 2'd2
) (
  input logic eboxClk,
  input logic eboxReset_n,
  edp_muldiv_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    FIX,
    DONE
  } state_t;

  localparam logic [5:0] LAST = 6'(STEPS - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       op_q, op_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            op_d    = bus.opDiv;
            state_d = LOAD;
          end
        end
        LOAD: begin
          cnt_d   = 6'd0;
          state_d = STEP;
        end
        STEP: begin
          if (cnt_q == LAST)
            state_d = op_q ? FIX : DONE;
          else
            cnt_d = cnt_q + 6'd1;
        end
        FIX:  state_d = DONE;
        DONE: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  logic [6:0] ad;
  logic       use_b;
  logic       br_ld;
  logic [2:0] ar_sel;
  logic       ar_ld;
  logic       ar_clr;
  logic [1:0] mq_sel;
  logic       ad_long;
  logic       done_p;

  // Abort kills the controls in the very cycle it is seen.
  always_comb begin
    ad      = 7'd0;
    use_b   = 1'b0;
    br_ld   = 1'b0;
    ar_sel  = 3'd0;
    ar_ld   = 1'b0;
    ar_clr  = 1'b0;
    mq_sel  = 2'd0;
    ad_long = 1'b0;
    done_p  = 1'b0;
    if (!bus.abort) begin
      unique case (state_q)
        LOAD: begin
          br_ld  = 1'b1;
          ar_clr = !op_q;
        end
        STEP: begin
          ar_ld   = 1'b1;
          ad_long = 1'b1;
          if (op_q) begin
            ad     = bus.arSign ? AD_APB : AD_AMB;
            use_b  = 1'b1;
            ar_sel = SEL_ADSHL;
            mq_sel = MQ_SHL;
          end else begin
            ad     = bus.mq35 ? AD_APB : AD_A;
            use_b  = bus.mq35;
            ar_sel = SEL_ADSHR;
            mq_sel = MQ_SHR;
          end
        end
        FIX: begin
          if (bus.arSign) begin
            ad     = AD_APB;
            use_b  = 1'b1;
            ar_sel = SEL_AD;
            ar_ld  = 1'b1;
          end
        end
        DONE:    done_p = 1'b1;
        default: done_p = 1'b0;
      endcase
    end
  end

  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = done_p;
  assign bus.stepCount        = cnt_q;
  assign bus.CRAM_AD          = ad;
  assign bus.CRAM_ADB         = use_b ? 3'd2 : 3'd0;
  assign bus.CRAM_BRload      = br_ld;
  assign bus.CTL_ARL_SEL      = ar_sel;
  assign bus.CTL_ARR_SEL      = ar_sel;
  assign bus.CTL_AR00to08load = ar_ld;
  assign bus.CTL_AR09to17load = ar_ld;
  assign bus.CTL_ARRload      = ar_ld;
  assign bus.CTL_AR00to11clr  = ar_clr;
  assign bus.CTL_AR12to17clr  = ar_clr;
  assign bus.CTL_ARRclr       = ar_clr;
  assign bus.CTL_MQ_SEL       = mq_sel;
  assign bus.CTL_ADlong       = ad_long;

endmodule
